// File: rtl/ring_rr_arbiter.sv
// ring_rr_arbiter: round-robin arbiter with one-hot ring pointer and per-tenure hold limit
// Ports:
//   clk       rising-edge clock
//   res       synchronous active-high reset
//   req       level requests, one bit per requester
//   grant     registered one-hot grant, zero when idle
//   grant_id  binary index of the granted requester, zero when idle
//   busy      high while any grant bit is set
//   ptr       one-hot priority pointer, ptr[i] marks the top-priority requester
//   timeout   one-cycle pulse in the dead cycle after a tenure is cut at MAX_HOLD
module ring_rr_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8,
   parameter int HOLD_W   = 4,
   parameter int ID_W     = 2
) (
   input  logic            clk,
   input  logic            res,
   input  logic [N-1:0]    req,
   output logic [N-1:0]    grant,
   output logic [ID_W-1:0] grant_id,
   output logic            busy,
   output logic [N-1:0]    ptr,
   output logic            timeout
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t            state_q, state_nx;
   logic [N-1:0]      grant_q, grant_nx, ptr_q, ptr_nx;
   logic [ID_W-1:0]   id_q, id_nx, ptr_idx, win_idx;
   logic [HOLD_W-1:0] hold_q, hold_nx;
   logic              busy_q, busy_nx, timeout_q, timeout_nx, found, keep, at_limit;
   // upward scan from the pointer position, wrapping; the lowest offset wins
   always_comb begin
      ptr_idx = '0;
      for (int i = 0; i < N; i++) if (ptr_q[i]) ptr_idx = ID_W'(i);
      found   = 1'b0;
      win_idx = '0;
      for (int k = N - 1; k >= 0; k--)
         if (req[(int'(ptr_idx) + k) % N]) begin
            found   = 1'b1;
            win_idx = ID_W'((int'(ptr_idx) + k) % N);
         end
   end
   always_ff @(posedge clk) begin
      if (res) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         id_q      <= '0;
         busy_q    <= 1'b0;
         ptr_q     <= {{(N-1){1'b0}}, 1'b1};
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_nx;
         grant_q   <= grant_nx;
         id_q      <= id_nx;
         busy_q    <= busy_nx;
         ptr_q     <= ptr_nx;
         hold_q    <= hold_nx;
         timeout_q <= timeout_nx;
      end
   end
   // a tenure continues only while the holder still requests and the limit is not reached
   always_comb begin
      keep       = req[id_q];
      at_limit   = hold_q == HOLD_W'(MAX_HOLD);
      state_nx   = state_q;
      grant_nx   = grant_q;
      id_nx      = id_q;
      busy_nx    = busy_q;
      ptr_nx     = ptr_q;
      hold_nx    = hold_q;
      timeout_nx = 1'b0;
      if (state_q == IDLE) begin
         if (found) begin
            state_nx = GRANT;
            grant_nx = {{(N-1){1'b0}}, 1'b1} << win_idx;
            id_nx    = win_idx;
            busy_nx  = 1'b1;
            hold_nx  = HOLD_W'(1);
         end
      end else if (!keep || at_limit) begin
         state_nx   = IDLE;
         grant_nx   = '0;
         id_nx      = '0;
         busy_nx    = 1'b0;
         hold_nx    = '0;
         ptr_nx     = {grant_q[N-2:0], grant_q[N-1]};
         timeout_nx = keep;
      end else begin
         hold_nx = hold_q + HOLD_W'(1);
      end
   end
   always_comb begin
      grant    = grant_q;
      grant_id = id_q;
      busy     = busy_q;
      ptr      = ptr_q;
      timeout  = timeout_q;
   end
endmodule

// File: tb/tb_ring_rr_arbiter.sv
// tb_ring_rr_arbiter: directed self-checking bench for ring_rr_arbiter
module tb_ring_rr_arbiter;
   logic       clk = 1'b0;
   logic       res = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [3:0] grant, ptr;
   logic [1:0] grant_id;
   logic       busy, timeout;
   logic [11:0] obs, exp;
   int checks = 0;
   int errors = 0;
   ring_rr_arbiter #(.N(4), .MAX_HOLD(8), .HOLD_W(4), .ID_W(2)) dut (
      .clk(clk), .res(res), .req(req), .grant(grant), .grant_id(grant_id),
      .busy(busy), .ptr(ptr), .timeout(timeout)
   );
   always #5 clk = ~clk;
   assign obs = {grant, grant_id, busy, ptr, timeout};
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset;
      res = 1'b1;
      req = 4'b0000;
      step();
      res = 1'b0;
   endtask
   task automatic test_reset;
      res = 1'b1;
      req = 4'b1111;
      for (int c = 0; c < 2; c++) begin
         step();
         exp = {4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0};
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL reset c%0d got=%b want=%b", c, obs, exp); end
      end
      res = 1'b0;
      req = 4'b0000;
      step();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_idle got=%b want=%b", obs, exp); end
   endtask
   task automatic test_single;
      req = 4'b0100;
      for (int c = 0; c < 3; c++) begin
         step();
         exp = {4'b0100, 2'd2, 1'b1, 4'b0001, 1'b0};
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL single c%0d got=%b want=%b", c, obs, exp); end
      end
      req = 4'b0000;
      step();
      exp = {4'b0000, 2'd0, 1'b0, 4'b1000, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL single_release got=%b want=%b", obs, exp); end
   endtask
   task automatic test_no_latch;
      req = 4'b0001;
      #2;
      req = 4'b0000;
      step();
      exp = {4'b0000, 2'd0, 1'b0, 4'b1000, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL no_latch got=%b want=%b", obs, exp); end
   endtask
   task automatic test_contention;
      logic [3:0] g_tab [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [1:0] i_tab [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [3:0] p_tab [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      do_reset();
      req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         for (int c = 0; c < 8; c++) begin
            step();
            exp = {g_tab[t], i_tab[t], 1'b1, g_tab[t], 1'b0};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL contention t%0d c%0d got=%b want=%b", t, c, obs, exp); end
         end
         step();
         exp = {4'b0000, 2'd0, 1'b0, p_tab[t], 1'b1};
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL contention_dead t%0d got=%b want=%b", t, obs, exp); end
      end
      req = 4'b0000;
      step();
      exp = {4'b0000, 2'd0, 1'b0, 4'b0010, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL contention_idle got=%b want=%b", obs, exp); end
   endtask
   task automatic test_wrap;
      do_reset();
      req = 4'b0100;
      step();
      req = 4'b0000;
      step();
      exp = {4'b0000, 2'd0, 1'b0, 4'b1000, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL wrap_setup got=%b want=%b", obs, exp); end
      req = 4'b0011;
      step();
      exp = {4'b0001, 2'd0, 1'b1, 4'b1000, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL wrap_first got=%b want=%b", obs, exp); end
      req = 4'b0010;
      step();
      exp = {4'b0000, 2'd0, 1'b0, 4'b0010, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL wrap_release got=%b want=%b", obs, exp); end
      step();
      exp = {4'b0010, 2'd1, 1'b1, 4'b0010, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL wrap_second got=%b want=%b", obs, exp); end
      req = 4'b0000;
      step();
      exp = {4'b0000, 2'd0, 1'b0, 4'b0100, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL wrap_end got=%b want=%b", obs, exp); end
   endtask
   task automatic test_lone_timeout;
      do_reset();
      req = 4'b0010;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (k == 9 || k == 18) exp = {4'b0000, 2'd0, 1'b0, 4'b0100, 1'b1};
         else exp = {4'b0010, 2'd1, 1'b1, (k < 9) ? 4'b0001 : 4'b0100, 1'b0};
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL lone k%0d got=%b want=%b", k, obs, exp); end
      end
      req = 4'b0000;
      step();
      exp = {4'b0000, 2'd0, 1'b0, 4'b0100, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL lone_end got=%b want=%b", obs, exp); end
   endtask
   task automatic test_reset_mid;
      do_reset();
      req = 4'b0100;
      for (int c = 0; c < 5; c++) step();
      exp = {4'b0100, 2'd2, 1'b1, 4'b0001, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL mid_pre got=%b want=%b", obs, exp); end
      res = 1'b1;
      step();
      exp = {4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL mid_reset got=%b want=%b", obs, exp); end
      res = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         step();
         exp = (c == 9) ? {4'b0000, 2'd0, 1'b0, 4'b1000, 1'b1} : {4'b0100, 2'd2, 1'b1, 4'b0001, 1'b0};
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL mid_regrant c%0d got=%b want=%b", c, obs, exp); end
      end
      req = 4'b0000;
      step();
   endtask
   initial begin
      test_reset();
      test_single();
      test_no_latch();
      test_contention();
      test_wrap();
      test_lone_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
